// File: rtl/vent_pkg.sv
// Shared vent scheduler types: state encoding, SPI op-codes, sensor frame layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vent_pkg;

  // State encoding is also the value reported on state_out.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_MANUAL    = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [7:0] OP_MANUAL = 8'hA5;
  localparam logic [7:0] OP_AUTO   = 8'h5A;

  // Bit offsets of the fields inside the 40-bit sensor frame.
  localparam int FRM_HUM_LSB  = 24;
  localparam int FRM_TEMP_LSB = 8;
  localparam int FRM_CSUM_LSB = 0;

  // 8-bit wrap-around byte sum over humidity and temperature.
  function automatic logic [7:0] frame_sum(input logic [15:0] hum, input logic [15:0] temp);
    return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
  endfunction

endpackage

// File: rtl/dht_frame_check.sv
// Sensor frame checksum compare and humidity field extraction.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluates whatever frame is presented.
module dht_frame_check
  import vent_pkg::*;
(
  input  logic [39:0] frame,
  output logic        good,
  output logic [15:0] hum
);

  logic [15:0] temp;
  logic [7:0]  csum;

  assign hum  = frame[FRM_HUM_LSB  +: 16];
  assign temp = frame[FRM_TEMP_LSB +: 16];
  assign csum = frame[FRM_CSUM_LSB +: 8];

  // Frame is good when the byte sum matches the transmitted checksum.
  always_comb begin
    good = (frame_sum(hum, temp) == csum);
  end

endmodule

// File: rtl/vent_sched.sv
// Humidity-driven vent scheduler: hysteresis FSM, duty ramp, frame/timeout fault, SPI manual override.
// Latency: state and duty update one cycle after the causing strobe; humidity decisions see hum_reg one cycle later.
// Backpressure: none; every tick, frame and command strobe is consumed in its cycle.
module vent_sched
  import vent_pkg::*;
#(
  parameter logic [15:0] HI_TH     = 16'd700,
  parameter logic [15:0] LO_TH     = 16'd600,
  parameter logic [7:0]  MAX_DUTY  = 8'd255,
  parameter logic [7:0]  RAMP_STEP = 8'd1,
  parameter logic [1:0]  BAD_LIMIT = 2'd3,
  parameter logic [15:0] TIMEOUT   = 16'd10000
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        tick_1ms,
  input  logic [39:0] hym_frame,
  input  logic        frame_valid,
  input  logic [15:0] cmd_word,
  input  logic        cmd_valid,
  output logic [7:0]  duty_out,
  output logic        vent_on,
  output logic        fault,
  output logic [2:0]  state_out
);

  state_t      state, state_nxt;
  logic [15:0] hum_reg;
  logic [1:0]  bad_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  man_duty, man_duty_nxt;
  logic [7:0]  target, duty_nxt;

  logic        frm_good_raw;
  logic [15:0] frm_hum;
  logic        frm_good, frm_bad;
  logic        cmd_man, cmd_auto, fault_cond;

  dht_frame_check u_chk (
    .frame (hym_frame),
    .good  (frm_good_raw),
    .hum   (frm_hum)
  );

  // Qualify strobes and decode the command op-code.
  always_comb begin
    frm_good     = frame_valid && frm_good_raw;
    frm_bad      = frame_valid && !frm_good_raw;
    cmd_man      = cmd_valid && (cmd_word[15:8] == OP_MANUAL);
    cmd_auto     = cmd_valid && (cmd_word[15:8] == OP_AUTO);
    fault_cond   = (bad_cnt == BAD_LIMIT) || (to_cnt == TIMEOUT);
    man_duty_nxt = cmd_man ? cmd_word[7:0] : man_duty;
  end

  // Next state: command first, then MANUAL/FAULT exits, then fault, then humidity hysteresis.
  always_comb begin
    state_nxt = state;
    if (cmd_man) begin
      state_nxt = ST_MANUAL;
    end else if (state == ST_MANUAL) begin
      if (cmd_auto) state_nxt = ST_RAMP_DOWN;
    end else if (state == ST_FAULT) begin
      // Recovery decides on the fresh frame, since hum_reg has not caught up yet.
      if (frm_good) state_nxt = (frm_hum > LO_TH) ? ST_ON : ST_RAMP_DOWN;
    end else if (fault_cond) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:      if (hum_reg > HI_TH) state_nxt = ST_RAMP_UP;
        ST_RAMP_UP: begin
          if (duty_out == MAX_DUTY)  state_nxt = ST_ON;
          else if (hum_reg < LO_TH)  state_nxt = ST_RAMP_DOWN;
        end
        ST_ON:        if (hum_reg < LO_TH) state_nxt = ST_RAMP_DOWN;
        ST_RAMP_DOWN: begin
          if (duty_out == 8'd0)      state_nxt = ST_IDLE;
          else if (hum_reg > HI_TH)  state_nxt = ST_RAMP_UP;
        end
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Duty target follows the state being entered; ramp clamps at the target.
  always_comb begin
    case (state_nxt)
      ST_RAMP_UP, ST_ON, ST_FAULT: target = MAX_DUTY;
      ST_MANUAL:                   target = man_duty_nxt;
      default:                     target = 8'd0;
    endcase
    duty_nxt = duty_out;
    if (state_nxt == ST_FAULT && state != ST_FAULT) begin
      duty_nxt = MAX_DUTY;
    end else if (tick_1ms) begin
      if (duty_out < target)
        duty_nxt = ((target - duty_out) > RAMP_STEP) ? duty_out + RAMP_STEP : target;
      else if (duty_out > target)
        duty_nxt = ((duty_out - target) > RAMP_STEP) ? duty_out - RAMP_STEP : target;
    end
  end

  // State, counters and registered outputs; reset overrides every strobe.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state     <= ST_IDLE;
      duty_out  <= 8'd0;
      vent_on   <= 1'b0;
      fault     <= 1'b0;
      state_out <= 3'd0;
      hum_reg   <= 16'd0;
      bad_cnt   <= 2'd0;
      to_cnt    <= 16'd0;
      man_duty  <= 8'd0;
    end else begin
      state     <= state_nxt;
      duty_out  <= duty_nxt;
      vent_on   <= (duty_nxt != 8'd0);
      fault     <= (state_nxt == ST_FAULT);
      state_out <= state_nxt;
      man_duty  <= man_duty_nxt;
      if (frm_good) begin
        hum_reg <= frm_hum;
        bad_cnt <= 2'd0;
        to_cnt  <= 16'd0;
      end else begin
        if (frm_bad && bad_cnt != BAD_LIMIT) bad_cnt <= bad_cnt + 2'd1;
        if (tick_1ms && to_cnt != TIMEOUT)   to_cnt  <= to_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vent_sched.sv
// Scoreboard bench for vent_sched: stimulus queues expected snapshots, a monitor
// compares them on every state_out change or on an explicit probe strobe.
// Timing: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_vent_sched;

  logic        clk50M = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1ms = 1'b0;
  logic [39:0] hym_frame = 40'd0;
  logic        frame_valid = 1'b0;
  logic [15:0] cmd_word = 16'd0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  duty_out;
  logic        vent_on;
  logic        fault;
  logic [2:0]  state_out;

  vent_sched dut (
    .clk50M      (clk50M),
    .rst         (rst),
    .tick_1ms    (tick_1ms),
    .hym_frame   (hym_frame),
    .frame_valid (frame_valid),
    .cmd_word    (cmd_word),
    .cmd_valid   (cmd_valid),
    .duty_out    (duty_out),
    .vent_on     (vent_on),
    .fault       (fault),
    .state_out   (state_out)
  );

  always #10 clk50M = ~clk50M;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] duty;
    logic       flt;
    logic       von;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    compared = 0;
  int    failed = 0;
  logic  mon_en = 1'b0;
  logic  snap = 1'b0;
  logic [2:0] prev_st = 3'd0;

  // Monitor: one comparison per state_out change or probe request.
  initial begin
    snap_t got, e;
    string nm;
    forever begin
      @(negedge clk50M);
      if (mon_en && (snap || state_out != prev_st)) begin
        got = '{st: state_out, duty: duty_out, flt: fault, von: vent_on};
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_event: got st=%0d duty=%0d fault=%0b vent_on=%0b, nothing expected",
                   got.st, got.duty, got.flt, got.von);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (got !== e) begin
            failed++;
            $display("FAIL %s: got st=%0d duty=%0d fault=%0b vent_on=%0b, want st=%0d duty=%0d fault=%0b vent_on=%0b",
                     nm, got.st, got.duty, got.flt, got.von, e.st, e.duty, e.flt, e.von);
          end
        end
      end
      prev_st = state_out;
    end
  end

  task automatic step();
    @(posedge clk50M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_ev(input string nm, input logic [2:0] s, input logic [7:0] d,
                           input logic f, input logic v);
    exp_q.push_back('{st: s, duty: d, flt: f, von: v});
    name_q.push_back(nm);
  endtask

  task automatic probe(input string nm, input logic [2:0] s, input logic [7:0] d,
                       input logic f, input logic v);
    expect_ev(nm, s, d, f, v);
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  function automatic logic [39:0] mk_frame(input logic [15:0] h, input logic [15:0] t, input bit ok);
    logic [7:0] c;
    c = h[15:8] + h[7:0] + t[15:8] + t[7:0];
    if (!ok) c = c ^ 8'h5A;
    return {h, t, c};
  endfunction

  task automatic send_raw(input logic [39:0] f);
    hym_frame   = f;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    step();
  endtask

  task automatic send_frame(input logic [15:0] h, input bit ok);
    send_raw(mk_frame(h, 16'd250, ok));
  endtask

  task automatic send_cmd(input logic [15:0] w);
    cmd_word  = w;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
      step();
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (state_out == s) hit = 1'b1;
      else step();
    end
    if (!hit) begin
      compared++;
      failed++;
      $display("FAIL %s_timeout: state_out=%0d, want %0d within %0d cycles", nm, state_out, s, budget);
    end
  endtask

  initial begin
    // Reset while strobes are active: all of them must be ignored.
    tick_1ms    = 1'b1;
    cmd_word    = 16'hA5FF;
    cmd_valid   = 1'b1;
    hym_frame   = mk_frame(16'd750, 16'd250, 1'b1);
    frame_valid = 1'b1;
    idle(3);
    rst = 1'b0; tick_1ms = 1'b0; cmd_valid = 1'b0; frame_valid = 1'b0;
    mon_en = 1'b1;
    idle(2);
    probe("reset_state", 3'd0, 8'd0, 1'b0, 1'b0);

    // Rise above HI_TH: hum 750 / temp 250 -> csum 0xEA, hand computed.
    expect_ev("enter_ramp_up", 3'd1, 8'd0, 1'b0, 1'b0);
    expect_ev("enter_on", 3'd2, 8'd255, 1'b0, 1'b1);
    send_raw(40'h02EE_00FA_EA);
    wait_state("ramp_up", 3'd1, 10);
    tick_n(255);
    wait_state("on", 3'd2, 10);

    // Exactly LO_TH does not start ramp-down.
    send_frame(16'd600, 1'b1);
    idle(4);
    probe("on_hold_at_lo_th", 3'd2, 8'd255, 1'b0, 1'b1);

    // Drop below LO_TH: ramp down to IDLE.
    expect_ev("enter_ramp_down", 3'd3, 8'd255, 1'b0, 1'b1);
    expect_ev("enter_idle", 3'd0, 8'd0, 1'b0, 1'b0);
    send_frame(16'd550, 1'b1);
    wait_state("ramp_down", 3'd3, 10);
    tick_n(255);
    wait_state("idle", 3'd0, 10);

    // Exactly HI_TH does not start ramp-up.
    send_frame(16'd700, 1'b1);
    idle(4);
    probe("idle_hold_at_hi_th", 3'd0, 8'd0, 1'b0, 1'b0);

    // Two bad frames are tolerated, the third faults.
    send_frame(16'd900, 1'b0);
    send_frame(16'd900, 1'b0);
    idle(4);
    probe("two_bad_no_fault", 3'd0, 8'd0, 1'b0, 1'b0);
    expect_ev("bad_frame_fault", 3'd5, 8'd255, 1'b1, 1'b1);
    send_frame(16'd900, 1'b0);
    wait_state("fault_bad", 3'd5, 10);

    // Recovery with hum at or below LO_TH goes to RAMP_DOWN.
    expect_ev("fault_to_ramp_down", 3'd3, 8'd255, 1'b0, 1'b1);
    expect_ev("recover_idle", 3'd0, 8'd0, 1'b0, 1'b0);
    send_frame(16'd500, 1'b1);
    wait_state("recover_rd", 3'd3, 10);
    tick_n(255);
    wait_state("recover_idle", 3'd0, 10);

    // Timeout: a good frame at tick 9999 restarts the count; 10000 silent ticks fault.
    rst = 1'b1; step(); rst = 1'b0;
    probe("reset_again", 3'd0, 8'd0, 1'b0, 1'b0);
    tick_n(9999);
    send_frame(16'd650, 1'b1);
    tick_n(9999);
    idle(2);
    probe("no_timeout_9999", 3'd0, 8'd0, 1'b0, 1'b0);
    expect_ev("timeout_fault", 3'd5, 8'd255, 1'b1, 1'b1);
    tick_n(1);
    wait_state("timeout", 3'd5, 10);

    // Recovery with hum above LO_TH goes straight to ON.
    expect_ev("fault_to_on", 3'd2, 8'd255, 1'b0, 1'b1);
    send_frame(16'd650, 1'b1);
    wait_state("fault_on", 3'd2, 10);

    // Manual override: duty ramps down to 0x80 and holds there.
    expect_ev("enter_manual", 3'd4, 8'd255, 1'b0, 1'b1);
    send_cmd(16'hA580);
    wait_state("manual", 3'd4, 10);
    tick_n(127);
    idle(2);
    probe("manual_duty_128", 3'd4, 8'd128, 1'b0, 1'b1);
    tick_n(5);
    probe("manual_no_overshoot", 3'd4, 8'd128, 1'b0, 1'b1);
    send_cmd(16'h1234);
    probe("unknown_op_ignored", 3'd4, 8'd128, 1'b0, 1'b1);
    send_frame(16'd900, 1'b0);
    send_frame(16'd900, 1'b0);
    send_frame(16'd900, 1'b0);
    idle(4);
    probe("manual_ignores_bad", 3'd4, 8'd128, 1'b0, 1'b1);

    // Leaving MANUAL with bad_cnt saturated: RAMP_DOWN for one cycle, then FAULT.
    expect_ev("auto_to_ramp_down", 3'd3, 8'd128, 1'b0, 1'b1);
    expect_ev("auto_then_fault", 3'd5, 8'd255, 1'b1, 1'b1);
    send_cmd(16'h5A00);
    wait_state("auto_fault", 3'd5, 10);
    send_cmd(16'h5A00);
    probe("auto_outside_manual", 3'd5, 8'd255, 1'b1, 1'b1);

    // Command and good frame together: command wins.
    expect_ev("cmd_beats_frame", 3'd4, 8'd255, 1'b0, 1'b1);
    hym_frame   = mk_frame(16'd650, 16'd250, 1'b1);
    frame_valid = 1'b1;
    cmd_word    = 16'hA540;
    cmd_valid   = 1'b1;
    step();
    frame_valid = 1'b0;
    cmd_valid   = 1'b0;
    wait_state("cmd_frame", 3'd4, 10);
    idle(3);
    probe("manual_stays", 3'd4, 8'd255, 1'b0, 1'b1);

    // Reset mid-ramp with a coincident manual command.
    expect_ev("reset_from_manual", 3'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    idle(2);
    expect_ev("ramp_up_again", 3'd1, 8'd0, 1'b0, 1'b0);
    send_frame(16'd750, 1'b1);
    wait_state("ramp_up2", 3'd1, 10);
    tick_n(100);
    idle(2);
    probe("mid_ramp_100", 3'd1, 8'd100, 1'b0, 1'b1);
    expect_ev("reset_mid_ramp", 3'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b1; cmd_word = 16'hA5FF; cmd_valid = 1'b1; tick_1ms = 1'b1;
    step();
    rst = 1'b0; cmd_valid = 1'b0; tick_1ms = 1'b0;
    idle(4);
    probe("reset_drops_cmd", 3'd0, 8'd0, 1'b0, 1'b0);

    idle(3);
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL leftover_expect: %0d events never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/vent_sched.md
VENT_SCHED -- requirements
Module: vent_sched

Interface
REQ-001 Parameters: HI_TH 16'd700 (on-threshold, %RH x10); LO_TH 16'd600 (off-threshold, %RH x10); MAX_DUTY 8'd255; RAMP_STEP 8'd1 (duty change per tick); BAD_LIMIT 2'd3 (consecutive bad frames before fault); TIMEOUT 16'd10000 (ticks without a good frame before fault).
REQ-002 Ports: clk50M  in  1  system clock (only clock).
REQ-003 Ports: rst  in  1  synchronous active-high reset.
REQ-004 Ports: tick_1ms  in  1  one-cycle strobe, 1 kHz.
REQ-005 Ports: hym_frame  in  40  humidity sensor frame {hum[15:0], temp[15:0], csum[7:0]}.
REQ-006 Ports: frame_valid  in  1  one-cycle strobe; hym_frame is stable in that cycle.
REQ-007 Ports: cmd_word  in  16  SPI command {op[7:0], arg[7:0]}.
REQ-008 Ports: cmd_valid  in  1  one-cycle strobe qualifying cmd_word.
REQ-009 Ports: duty_out  out  8  vent PWM duty to the PWM block.
REQ-010 Ports: vent_on  out  1  high when duty_out != 0.
REQ-011 Ports: fault  out  1  high in FAULT state.
REQ-012 Ports: state_out  out  3  current state encoding, readable over SPI.

Function
REQ-013 Frame check: the frame is good when (hum[15:8]+hum[7:0]+temp[15:8]+temp[7:0]) mod 256 == csum; the sum uses 8-bit wrap-around.
REQ-014 A good frame latches hum into hum_reg, clears bad_cnt and clears the timeout counter; a bad frame increments bad_cnt, saturating at BAD_LIMIT, and leaves hum_reg unchanged.
REQ-015 The timeout counter increments on each tick_1ms and saturates at TIMEOUT.
REQ-016 States: IDLE, RAMP_UP, ON, RAMP_DOWN, MANUAL, FAULT.
REQ-017 Target duty:
  - RAMP_UP, ON, FAULT: MAX_DUTY.
  - IDLE, RAMP_DOWN: 0.
  - MANUAL: man_duty.
REQ-018 On each tick_1ms, duty_out moves toward the target by RAMP_STEP, clamped so it never overshoots the target. FAULT is the exception: duty_out is set to MAX_DUTY in the cycle FAULT is entered.
REQ-019 The next state is evaluated every cycle from hum_reg as updated by the previous cycle; decisions use strict compares (hum_reg > HI_TH, hum_reg < LO_TH).
REQ-020 IDLE -> RAMP_UP when hum_reg > HI_TH.
REQ-021 RAMP_UP -> ON when duty_out == MAX_DUTY; RAMP_UP -> RAMP_DOWN when hum_reg < LO_TH.
REQ-022 ON -> RAMP_DOWN when hum_reg < LO_TH.
REQ-023 RAMP_DOWN -> IDLE when duty_out == 0; RAMP_DOWN -> RAMP_UP when hum_reg > HI_TH.
REQ-024 Any non-MANUAL state -> FAULT when bad_cnt == BAD_LIMIT or the timeout counter == TIMEOUT.
REQ-025 FAULT -> ON on a good frame with hum > LO_TH; FAULT -> RAMP_DOWN on a good frame with hum <= LO_TH.
REQ-026 Command 8'hA5 (any state) -> MANUAL, with man_duty <= arg; a repeated 8'hA5 while in MANUAL updates man_duty.
REQ-027 Command 8'h5A in MANUAL -> RAMP_DOWN; 8'h5A outside MANUAL is ignored.
REQ-028 All other op codes are ignored.
REQ-029 MANUAL ignores fault and timeout conditions for state transitions, but frames are still checked and the counters still update.
REQ-030 cmd_valid and frame_valid in the same cycle: both are consumed; the command transition has priority over fault and humidity transitions.
REQ-031 tick_1ms coincident with a state change: the duty step uses the target of the new state.
REQ-032 state_out encoding: IDLE 0, RAMP_UP 1, ON 2, RAMP_DOWN 3, MANUAL 4, FAULT 5.

Reset
REQ-033 On rst high at a clk50M edge: state IDLE, duty_out 0, vent_on 0, fault 0, state_out 0, hum_reg 0, bad_cnt 0, timeout counter 0, man_duty 0.
REQ-034 Reset has priority over every strobe in the same cycle, including mid-ramp and in MANUAL.

Structure
REQ-035 Shared package vent_pkg holds: the state encoding, the op-code constants (OP_MANUAL 8'hA5, OP_AUTO 8'h5A), and the frame field offsets.
REQ-036 One sub-module, dht_frame_check, performs the combinational checksum compare and field extraction (good, hum).
REQ-037 The state machine, counters and ramp logic are in vent_sched itself.

Verification
REQ-038 Good frame with hum = 750 from IDLE -> state_out 1; duty_out reaches 255 after 255 ticks, then state_out 2.
REQ-039 From ON, good frame with hum = 550 -> state_out 3; duty_out reaches 0 after 255 ticks, then state_out 0 and vent_on 0.
REQ-040 Three consecutive bad-csum frames in IDLE -> fault 1, duty_out 255 in the next cycle; a later good frame with hum = 500 -> state_out 3 and fault 0.
REQ-041 No frames for 10000 ticks -> FAULT; a good frame at tick 9999 prevents it.
REQ-042 cmd 16'hA580 -> MANUAL and duty ramps to 128; three bad frames -> no FAULT; cmd 16'h5A00 -> RAMP_DOWN.
REQ-043 rst asserted mid-RAMP_UP with duty_out = 100 -> duty_out 0 and state_out 0 in the next cycle; a simultaneous cmd_valid in the same cycle as rst is ignored.
